// File: rtl/mpt_memory_stage_if.sv
// mpt_memory_stage_if: valid/ready/data stream carrying one packed MPT walker
// transaction.
//   valid : producer has a transaction on data
//   ready : consumer accepts it this cycle
//   data  : packed transaction, DATA_WIDTH bits
// The master modport drives valid/data and the slave modport drives ready.
interface mpt_memory_stage_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/mpt_memory_stage.sv
// mpt_memory_stage: MPT walker stage that sits behind the forwarding buffer.
// A transaction marked WALKING_DO issues one memory read at its mpte_ptr. The
// returned entry is loaded into mpte and published once on the update port.
// The transaction is then handed to the next stage. SKIP and FWD transactions
// pass through unchanged.
//
// Ports:
//   clk_i, rst_ni      clock, async active-low reset
//   fwd_slave_stage    incoming transactions (ready only in IDLE)
//   fwd_update_master  one-cycle update pulse after a good read; consumer
//                      is always ready
//   mem_req_*          read request (valid/ready/addr)
//   mem_rsp_*          read response (valid/data/err)
//   next_master_stage  outgoing transactions
//   mem_access_cnt_o   number of accepted memory requests (wraps)
//
// Transaction layout, MSB first:
//   {valid, walking[1:0], mpte_ptr[PTR_W-1:0], mpte[MPTE_W-1:0]}
//   MPTE_W = (W-3)/2 and PTR_W = W-3-MPTE_W.
// The response data is truncated or zero-extended into mpte. The pointer is
// truncated or zero-extended onto the request address.
module mpt_memory_stage #(
    parameter int TRANSACTION_DATA_WIDTH = 32,
    parameter int MEM_ADDR_WIDTH         = 64,
    parameter int MEM_DATA_WIDTH         = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    mpt_memory_stage_if.slave         fwd_slave_stage,
    mpt_memory_stage_if.master        fwd_update_master,
    output logic                      mem_req_valid_o,
    input  logic                      mem_req_ready_i,
    output logic [MEM_ADDR_WIDTH-1:0] mem_req_addr_o,
    input  logic                      mem_rsp_valid_i,
    input  logic [MEM_DATA_WIDTH-1:0] mem_rsp_data_i,
    input  logic                      mem_rsp_err_i,
    mpt_memory_stage_if.master        next_master_stage,
    output logic [31:0]               mem_access_cnt_o
);
    localparam int W         = TRANSACTION_DATA_WIDTH;
    localparam int MPTE_W    = (W - 3) / 2;
    localparam int PTR_W     = W - 3 - MPTE_W;
    localparam int PTR_LSB   = MPTE_W;
    localparam int PTR_MSB   = MPTE_W + PTR_W - 1;
    localparam int WALK_LSB  = MPTE_W + PTR_W;
    localparam int VALID_BIT = W - 1;

    localparam logic [1:0] WALKING_DO = 2'd1;  // SKIP = 0 and FWD = 2 bypass

    typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;

    state_t         state_q;
    logic [W-1:0]   txn_q;
    logic [W-1:0]   in_data;
    logic           upd_valid_q;
    logic           out_valid_q;
    logic [31:0]    cnt_q;
    logic           unused_upd_ready;

    assign in_data          = fwd_slave_stage.data;
    assign unused_upd_ready = fwd_update_master.ready;

    // Every output is a register or a decode of state_q / txn_q. No input
    // reaches a valid output combinationally.
    assign fwd_slave_stage.ready    = (state_q == IDLE);
    assign fwd_update_master.valid  = upd_valid_q;
    assign fwd_update_master.data   = txn_q;
    assign next_master_stage.valid  = out_valid_q;
    assign next_master_stage.data   = txn_q;
    assign mem_access_cnt_o         = cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= IDLE;
            txn_q           <= '0;
            mem_req_valid_o <= 1'b0;
            mem_req_addr_o  <= '0;
            upd_valid_q     <= 1'b0;
            out_valid_q     <= 1'b0;
            cnt_q           <= '0;
        end else begin
            upd_valid_q <= 1'b0;  // update is a single-cycle pulse
            case (state_q)
                IDLE: begin
                    // A transfer whose .valid field is clear is consumed and
                    // dropped, because ready is high in IDLE.
                    if (fwd_slave_stage.valid && in_data[VALID_BIT]) begin
                        txn_q <= in_data;
                        if (in_data[WALK_LSB+1:WALK_LSB] == WALKING_DO) begin
                            state_q         <= REQ;
                            mem_req_valid_o <= 1'b1;
                            mem_req_addr_o  <= MEM_ADDR_WIDTH'(in_data[PTR_MSB:PTR_LSB]);
                        end else begin
                            state_q     <= OUT;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready_i) begin
                        mem_req_valid_o <= 1'b0;
                        cnt_q           <= cnt_q + 32'd1;
                        state_q         <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid_i) begin
                        // A faulting read leaves an all-zero (invalid) entry,
                        // which downstream reports as a fault.
                        txn_q[MPTE_W-1:0] <= mem_rsp_err_i ? '0 : MPTE_W'(mem_rsp_data_i);
                        upd_valid_q       <= ~mem_rsp_err_i;
                        out_valid_q       <= 1'b1;
                        state_q           <= OUT;
                    end
                end
                OUT: begin
                    if (next_master_stage.ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
